memd_port_arb: RTL

Sequencer for the single data-memory port used by the simpleooo core. Loads leave the execute stage with an address. Committed stores arrive from retirement. A one-cycle-latency synchronous SRAM is shared between the two. Committed stores are held in a small in-order store buffer. Store buffer drains are interleaved with loads under a priority and anti-starvation policy. Load-after-store ordering on the same address is enforced.

---
 rtl/memd_port_arb.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/memd_port_arb.sv
// Data-memory port sequencer: in-order committed-store buffer drained into a shared 1-cycle SRAM, interleaved with loads.
// Optional store-to-load forwarding is compiled in with `define MEMD_ARB_FWD_EN.
module memd_port_arb #(
  parameter int unsigned STB_DEPTH     = 4,
  parameter int unsigned STARVE_MAX    = 3,
  parameter int unsigned MEMD_SIZE_LOG = 8,
  parameter int unsigned REG_LEN       = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ld_valid,
  input  logic [MEMD_SIZE_LOG-1:0] ld_addr,
  input  logic [3:0]               ld_tag,
  output logic                     ld_ready,
  output logic                     ld_resp_valid,
  output logic [3:0]               ld_resp_tag,
  output logic [REG_LEN-1:0]       ld_resp_data,
  input  logic                     ld_kill,
  input  logic                     st_valid,
  input  logic [MEMD_SIZE_LOG-1:0] st_addr,
  input  logic [REG_LEN-1:0]       st_data,
  output logic                     st_ready,
  input  logic                     drain,
  output logic                     stb_empty,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [MEMD_SIZE_LOG-1:0] mem_addr,
  output logic [REG_LEN-1:0]       mem_wdata,
  input  logic [REG_LEN-1:0]       mem_rdata
);

  localparam int unsigned IW = $clog2(STB_DEPTH);
  localparam int unsigned PW = IW + 1;
  localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_LOAD,
    GNT_DRAIN
  } gnt_e;

  gnt_e                     gnt;
  logic [PW-1:0]            head_q, head_d;
  logic [PW-1:0]            tail_q, tail_d;
  logic [PW-1:0]            count;
  logic [SW-1:0]            starve_q, starve_d;
  logic                     resp_valid_q, resp_valid_d;
  logic [3:0]               resp_tag_q, resp_tag_d;
  logic [MEMD_SIZE_LOG-1:0] stb_addr_q [STB_DEPTH];
  logic [REG_LEN-1:0]       stb_data_q [STB_DEPTH];
  logic                     full, empty, conflict, starve_max;
  logic                     push, pop, fwd_hit;

`ifdef MEMD_ARB_FWD_EN
  logic [REG_LEN-1:0]       fwd_data;
  logic                     resp_fwd_q;
  logic [REG_LEN-1:0]       resp_fwd_data_q;
`endif

  assign count      = tail_q - head_q;
  assign empty      = (head_q == tail_q);
  assign full       = (head_q[IW-1:0] == tail_q[IW-1:0]) && (head_q[IW] != tail_q[IW]);
  assign starve_max = (starve_q == SW'(STARVE_MAX));
  assign st_ready   = !full;
  assign stb_empty  = empty;

  // Walk entries oldest to youngest so the last match is the youngest store.
  always_comb begin
    conflict = 1'b0;
`ifdef MEMD_ARB_FWD_EN
    fwd_data = '0;
`endif
    for (int unsigned k = 0; k < STB_DEPTH; k++) begin
      if ((PW'(k) < count) &&
          (stb_addr_q[IW'(head_q[IW-1:0] + IW'(k))] == ld_addr)) begin
        conflict = 1'b1;
`ifdef MEMD_ARB_FWD_EN
        fwd_data = stb_data_q[IW'(head_q[IW-1:0] + IW'(k))];
`endif
      end
    end
  end

  always_comb begin
    gnt = GNT_IDLE;
    if (rst_n) begin
      if (!empty && (full || drain || starve_max || !ld_valid || conflict)) begin
        gnt = GNT_DRAIN;
      end else if (ld_valid && !drain) begin
        gnt = GNT_LOAD;
      end
    end
  end

`ifdef MEMD_ARB_FWD_EN
  // A conflicting load never needs the port, so it rides alongside the drain.
  assign fwd_hit = rst_n && ld_valid && !drain && conflict;
`else
  assign fwd_hit = 1'b0;
`endif

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ld_ready  = 1'b0;
    unique case (gnt)
      GNT_DRAIN: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = stb_addr_q[head_q[IW-1:0]];
        mem_wdata = stb_data_q[head_q[IW-1:0]];
      end
      GNT_LOAD: begin
        mem_en   = 1'b1;
        mem_addr = ld_addr;
        ld_ready = 1'b1;
      end
      default: ;
    endcase
    if (fwd_hit) ld_ready = 1'b1;
  end

  assign push = st_valid && st_ready;
  assign pop  = (gnt == GNT_DRAIN);

  always_comb begin
    head_d = head_q + PW'(pop);
    tail_d = tail_q + PW'(push);

    starve_d = starve_q;
    if (pop || empty) begin
      starve_d = '0;
    end else if ((gnt == GNT_LOAD) && !starve_max) begin
      starve_d = starve_q + SW'(1);
    end

    resp_valid_d = ld_ready && !ld_kill;
    resp_tag_d   = ld_ready ? ld_tag : resp_tag_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= '0;
      tail_q       <= '0;
      starve_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_tag_q   <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      starve_q     <= starve_d;
      resp_valid_q <= resp_valid_d;
      resp_tag_q   <= resp_tag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      stb_addr_q[tail_q[IW-1:0]] <= st_addr;
      stb_data_q[tail_q[IW-1:0]] <= st_data;
    end
  end

`ifdef MEMD_ARB_FWD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_fwd_q      <= 1'b0;
      resp_fwd_data_q <= '0;
    end else begin
      resp_fwd_q <= fwd_hit;
      if (fwd_hit) resp_fwd_data_q <= fwd_data;
    end
  end

  assign ld_resp_data = resp_fwd_q ? resp_fwd_data_q : mem_rdata;
`else
  assign ld_resp_data = mem_rdata;
`endif

  // A kill in the response cycle suppresses a response already registered.
  assign ld_resp_valid = resp_valid_q && !ld_kill;
  assign ld_resp_tag   = resp_tag_q;

endmodule
